// File: rtl/prio_irq_encoder.sv
// Registered N-input priority encoder with rising-edge request latching, masking and ack handshake.
// Build option PRIO_RR_EN selects rotating priority; undefined gives fixed highest-index priority.
module prio_irq_encoder #(
    parameter  int N = 4,
    localparam int W = $clog2(N)
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [N-1:0] req,
    input  logic         mask_wr,
    input  logic [N-1:0] mask_in,
    input  logic         ack,
    output logic [W-1:0] code,
    output logic         valid,
    output logic [N-1:0] pending
);

    // state | meaning
    // IDLE  | no grant outstanding; grant the winner as soon as one is eligible
    // GRANT | code/valid frozen until the consumer acks
    typedef enum logic {IDLE, GRANT} state_t;

    state_t       state_q, state_nxt;
    logic [N-1:0] req_d, req_rise, clr, mask, eligible;
    logic [W-1:0] winner, code_nxt;
    logic         valid_nxt;

    assign req_rise = req & ~req_d;
    assign eligible = pending & ~mask;

    always_comb begin
        clr = '0;
        for (int k = 0; k < N; k++) begin
            clr[k] = ack & valid & (code == W'(k));
        end
    end

`ifdef PRIO_RR_EN
    logic [W-1:0] last;

    // Walk the order from lowest rank up so the last write is last-1, the top rank.
    always_comb begin
        winner = '0;
        for (int i = N; i >= 1; i--) begin
            if (eligible[(int'(last) + N - i) % N]) begin
                winner = W'((int'(last) + N - i) % N);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last <= '0;
        end else if (state_q == GRANT && ack) begin
            last <= code;
        end
    end
`else
    always_comb begin
        winner = '0;
        for (int k = 0; k < N; k++) begin
            if (eligible[k]) begin
                winner = W'(k);
            end
        end
    end
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            code    <= '0;
            valid   <= 1'b0;
            pending <= '0;
            mask    <= '0;
            req_d   <= '0;
        end else begin
            state_q <= state_nxt;
            code    <= code_nxt;
            valid   <= valid_nxt;
            pending <= req_rise | (pending & ~clr);
            req_d   <= req;
            if (mask_wr) begin
                mask <= mask_in;
            end
        end
    end

    always_comb begin
        state_nxt = state_q;
        case (state_q)
            IDLE:    if (|eligible) state_nxt = GRANT;
            GRANT:   if (ack)       state_nxt = IDLE;
            default:                state_nxt = IDLE;
        endcase
    end

    always_comb begin
        code_nxt  = code;
        valid_nxt = 1'b0;
        case (state_q)
            IDLE: begin
                if (|eligible) begin
                    code_nxt  = winner;
                    valid_nxt = 1'b1;
                end
            end
            GRANT: begin
                valid_nxt = ~ack;
            end
            default: begin
                valid_nxt = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_prio_irq_encoder.sv
// Directed bench for prio_irq_encoder: per-cycle comparison against a behavioural model
// plus literal expectations for the documented scenarios.
module tb_prio_irq_encoder;

    localparam int N = 4;
    localparam int W = 2;
`ifdef PRIO_RR_EN
    localparam bit RR = 1'b1;
`else
    localparam bit RR = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         rst_n = 1'b1;
    logic [N-1:0] req = '0;
    logic         mask_wr = 1'b0;
    logic [N-1:0] mask_in = '0;
    logic         ack = 1'b0;
    logic [W-1:0] code;
    logic         valid;
    logic [N-1:0] pending;

    int vectors = 0;
    int miscompares = 0;

    prio_irq_encoder #(.N(N)) dut (
        .clk(clk), .rst_n(rst_n), .req(req), .mask_wr(mask_wr), .mask_in(mask_in),
        .ack(ack), .code(code), .valid(valid), .pending(pending)
    );

    always #5 clk = ~clk;

    bit [N-1:0] m_pending, m_req_d, m_mask;
    bit [W-1:0] m_code;
    int         m_last;
    bit         m_valid;

    function automatic int pick(bit [N-1:0] elig, int last);
        if (RR) begin
            for (int i = 1; i <= N; i++) begin
                int idx;
                idx = ((last - i) % N + N) % N;
                if (elig[idx]) return idx;
            end
        end else begin
            for (int k = N - 1; k >= 0; k--) if (elig[k]) return k;
        end
        return -1;
    endfunction

    task automatic model_step();
        bit [N-1:0] nxt_pending;
        int w;
        for (int k = 0; k < N; k++) begin
            bit rose, served;
            rose   = req[k] && !m_req_d[k];
            served = ack && m_valid && (int'(m_code) == k);
            nxt_pending[k] = rose || (m_pending[k] && !served);
        end
        if (m_valid) begin
            if (ack) begin
                m_valid = 1'b0;
                m_last  = int'(m_code);
            end
        end else begin
            w = pick(m_pending & ~m_mask, m_last);
            if (w >= 0) begin
                m_code  = W'(w);
                m_valid = 1'b1;
            end
        end
        m_pending = nxt_pending;
        if (mask_wr) m_mask = mask_in;
        m_req_d = req;
    endtask

    initial begin
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) begin
                m_pending = '0; m_req_d = '0; m_mask = '0;
                m_code = '0; m_valid = 1'b0; m_last = 0;
            end else begin
                model_step();
            end
        end
    end

    task automatic chk(string name, int got, int exp);
        vectors++;
        if (got != exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
        end
    endtask

    initial begin
        forever begin
            @(negedge clk);
            chk("model_valid", int'(valid), int'(m_valid));
            chk("model_pending", int'(pending), int'(m_pending));
            if (m_valid) chk("model_code", int'(code), int'(m_code));
        end
    end

    task automatic cyc(int n = 1);
        repeat (n) @(negedge clk);
    endtask

    int grants;

    initial begin
        #1 rst_n = 1'b0;
        cyc(2);
        rst_n = 1'b1;
        cyc();
        chk("reset_valid", int'(valid), 0);
        chk("reset_code", int'(code), 0);
        chk("reset_pending", int'(pending), 0);

        // two lines at once: higher index first, bubble, then the lower one
        req = 4'b0110;
        cyc();
        chk("t2_pending", int'(pending), 4'b0110);
        chk("t2_no_grant_yet", int'(valid), 0);
        cyc();
        chk("t2_first_valid", int'(valid), 1);
        chk("t2_first_code", int'(code), 2);
        ack = 1'b1;
        cyc();
        ack = 1'b0;
        chk("t2_bubble", int'(valid), 0);
        cyc();
        chk("t2_second_code", int'(code), 1);
        chk("t2_second_valid", int'(valid), 1);
        ack = 1'b1;
        cyc();
        ack = 1'b0;
        req = '0;
        chk("t2_done_valid", int'(valid), 0);
        chk("t2_done_pending", int'(pending), 0);

        // masked line latches but is not granted until unmasked
        mask_wr = 1'b1; mask_in = 4'b0100;
        cyc();
        mask_wr = 1'b0;
        req = 4'b0100;
        cyc(3);
        chk("t3_masked_pending", int'(pending), 4'b0100);
        chk("t3_masked_valid", int'(valid), 0);
        mask_wr = 1'b1; mask_in = 4'b0000;
        cyc();
        mask_wr = 1'b0;
        cyc();
        chk("t3_unmask_code", int'(code), 2);
        chk("t3_unmask_valid", int'(valid), 1);
        ack = 1'b1; req = '0;
        cyc();
        ack = 1'b0;
        chk("t3_done_pending", int'(pending), 0);

        // stray ack while idle, then ack coincident with a fresh edge on the same line
        ack = 1'b1; req = 4'b0010;
        cyc();
        ack = 1'b0; req = '0;
        chk("t4_stray_ack_pending", int'(pending), 4'b0010);
        cyc();
        chk("t4_grant_code", int'(code), 1);
        chk("t4_grant_valid", int'(valid), 1);
        ack = 1'b1; req = 4'b0010;
        cyc();
        ack = 1'b0;
        chk("t4_set_wins_pending", int'(pending), 4'b0010);
        chk("t4_bubble", int'(valid), 0);
        cyc();
        chk("t4_regrant_code", int'(code), 1);
        chk("t4_regrant_valid", int'(valid), 1);
        ack = 1'b1; req = '0;
        cyc();
        ack = 1'b0;

        // no preemption; a held level yields one grant only
        req = 4'b0001;
        cyc(2);
        chk("t5_code0", int'(code), 0);
        req = 4'b1001;
        cyc(2);
        chk("t5_hold_code", int'(code), 0);
        chk("t5_hold_valid", int'(valid), 1);
        chk("t5_hold_pending", int'(pending), 4'b1001);
        ack = 1'b1;
        cyc();
        ack = 1'b0;
        cyc();
        chk("t5_code3", int'(code), 3);
        ack = 1'b1;
        cyc();
        ack = 1'b0;
        grants = 0;
        for (int i = 0; i < 10; i++) begin
            cyc();
            if (valid) grants++;
        end
        chk("t5_level_no_regrant", grants, 0);
        req = '0;
        cyc();

        // serve 3 while it re-raises in the ack cycle; the build decides the order after
        req = 4'b1000;
        cyc();
        req = 4'b0001;
        cyc();
        chk("t6_code3", int'(code), 3);
        chk("t6_pending", int'(pending), 4'b1001);
        ack = 1'b1; req = 4'b1001;
        cyc();
        ack = 1'b0;
        chk("t6_after_ack_pending", int'(pending), 4'b1001);
        cyc();
        chk("t6_next_first", int'(code), RR ? 0 : 3);
        ack = 1'b1;
        cyc();
        ack = 1'b0;
        cyc();
        chk("t6_next_second", int'(code), RR ? 3 : 0);
        chk("t6_next_second_valid", int'(valid), 1);
        ack = 1'b1; req = '0;
        cyc();
        ack = 1'b0;
        chk("t6_done_pending", int'(pending), 0);

        // asynchronous reset while a grant is live
        req = 4'b0100;
        cyc(2);
        chk("t1_pre_valid", int'(valid), 1);
        #2 rst_n = 1'b0;
        #1;
        chk("t1_async_valid", int'(valid), 0);
        chk("t1_async_code", int'(code), 0);
        chk("t1_async_pending", int'(pending), 0);
        req = '0;
        cyc();
        rst_n = 1'b1;
        cyc(2);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
